control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.
- Drives write enables and mux selects for the PC, MAR, MBR, IR and ACC registers, plus the main memory and the ALU opcode.
- Consumes the IR contents and the ACC value; produces no datapath values itself.
- Sits between the register file/memory datapath and the top-level computer, replacing the single-step instruction stepper.

Parameters:
- OPC_W, 4, opcode field width (IR[15:12]).
- ADDR_W, 12, operand address field width (IR[11:0]); the datapath zero-extends it to 16 bits.
- HALT_ON_ILLEGAL, 0, 1 = an undefined opcode enters HALT; 0 = it executes as a NOP.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  start/continue; sampled only in F_MAR.
- ir_in  in  16  current IR contents.
- acc_in  in  16  current ACC contents (two's complement), used by SKIPCOND.
- pc_we  out  1  PC write enable.
- pc_sel  out  1  PC source: 0 = PC+1, 1 = IR address.
- mar_we  out  1  MAR write enable.
- mar_sel  out  1  MAR source: 0 = PC, 1 = IR address.
- mbr_we  out  1  MBR write enable.
- mbr_sel  out  1  MBR source: 0 = memory data_out, 1 = ACC.
- ir_we  out  1  IR write enable (IR source is MBR).
- acc_we  out  1  ACC write enable.
- acc_sel  out  2  ACC source: 0 = MBR, 1 = ALU result, 2 = zero.
- alu_op  out  4  ALU opcode: 0000 = add, 0001 = sub; 0000 when unused.
- mem_we  out  1  memory write enable (memory address is MAR, data is MBR).
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an undefined opcode.
- halted  out  1  high while in HALT.
- state_dbg  out  4  current state encoding.

Behaviour:
- Outputs are combinational from (state, ir_in, acc_in). While reset is high, all outputs are forced to 0 except state_dbg. At the next edge with reset high, the state becomes F_MAR.
- Memory read latency is 1 cycle: data_out is valid in the cycle after the address is held in MAR.
- Fetch sequence:
  - F_MAR: if run=1, assert mar_we with mar_sel=0, go to F_RD. If run=0, assert nothing and stay in F_MAR.
  - F_RD: nothing asserted (memory read).
  - F_MBR: assert mbr_we with mbr_sel=0, and pc_we with pc_sel=0.
  - F_IR: assert ir_we. Next state is DECODE.
- DECODE, by ir_in[15:12]:
  - 1 LOAD, 3 ADD, 4 SUBT: assert mar_we with mar_sel=1, go to X_RD.
  - 2 STORE: assert mar_we with mar_sel=1, and mbr_we with mbr_sel=1; go to X_WR.
  - 7 HALT: assert instr_done, go to HALT.
  - 8 SKIPCOND, condition ir_in[11:10]: 00 = acc_in<0, 01 = acc_in==0, 10 = acc_in>0, 11 = never. If the condition is true, assert pc_we with pc_sel=0. Assert instr_done, go to F_MAR.
  - 9 JUMP: assert pc_we with pc_sel=1 and instr_done, go to F_MAR.
  - A CLEAR: assert acc_we with acc_sel=2 and instr_done, go to F_MAR.
  - Any other opcode: pulse illegal_op. If HALT_ON_ILLEGAL=1, go to HALT; otherwise assert instr_done and go to F_MAR.
- Execute states:
  - X_RD: nothing asserted.
  - X_MBR: assert mbr_we with mbr_sel=0.
  - X_ACC: assert acc_we and instr_done, go to F_MAR. LOAD uses acc_sel=0; ADD uses acc_sel=1, alu_op=0000; SUBT uses acc_sel=1, alu_op=0001.
  - X_WR: assert mem_we and instr_done, go to F_MAR.
- HALT: halted=1, no enables asserted. Exits only via reset; run is ignored.
- Latency in cycles, counted from F_MAR with run=1:
  - LOAD, ADD, SUBT: 8.
  - STORE: 6.
  - JUMP, CLEAR, SKIPCOND, illegal (NOP): 5.
  - HALT: 5 to halted=1.
- PC wrap-around (0xFFFF to 0x0000) is handled by the datapath; the sequencer does not detect it.
- Reset asserted mid-instruction aborts it: no partial write occurs after the reset edge, and the next state is F_MAR.
- run dropping mid-instruction has no effect until the next F_MAR.

Decomposition:
- Shared package `cpu_pkg`:
  - opcode constants (OP_LOAD=1, OP_STORE=2, OP_ADD=3, OP_SUBT=4, OP_HALT=7, OP_SKIPCOND=8, OP_JUMP=9, OP_CLEAR=A);
  - state encodings F_MAR=0, F_RD=1, F_MBR=2, F_IR=3, DECODE=4, X_RD=5, X_MBR=6, X_ACC=7, X_WR=8, HALT=9;
  - acc_sel, mbr_sel, pc_sel and mar_sel encodings;
  - ALU opcode constants.
- One sub-module, `skip_eval`: a combinational SKIPCOND condition evaluator taking (cond[1:0], acc[15:0]) and returning skip.

Test Plan:
- Reset with run=1, then ir_in=0x1005 (LOAD 5) -> cycle 1 mar_we/mar_sel=0; cycle 3 mbr_we and pc_we; cycle 4 ir_we; cycle 5 mar_we/mar_sel=1; cycle 7 mbr_we; cycle 8 acc_we/acc_sel=0 with instr_done=1; back in F_MAR on cycle 9.
- ir_in=0x4010 (SUBT) -> cycle 8 acc_we, acc_sel=1, alu_op=0001. ir_in=0x2020 (STORE) -> cycle 5 mar_we and mbr_we/mbr_sel=1; cycle 6 mem_we and instr_done; no acc_we at any point.
- ir_in=0x8400 (SKIPCOND ==0): with acc_in=0x0000 -> DECODE asserts pc_we/pc_sel=0. With acc_in=0x0003 -> no pc_we. ir_in=0x8000 with acc_in=0x8000 -> pc_we=1. ir_in=0x8C00 -> never skips.
- ir_in=0x9123 (JUMP) -> DECODE pc_we, pc_sel=1, instr_done. ir_in=0xA000 (CLEAR) -> acc_we with acc_sel=2.
- ir_in=0x7000 -> halted=1 from cycle 6, held for 20 cycles with run toggling; then reset -> halted=0, state_dbg=0. ir_in=0xF000 -> illegal_op pulses one cycle; with HALT_ON_ILLEGAL=0 execution continues, with HALT_ON_ILLEGAL=1 it enters HALT.
- run=0 after reset -> stays in F_MAR with all enables 0 for 10 cycles. Reset asserted in X_MBR of an ADD -> no acc_we follows; restarts at F_MAR.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, sequencer states, mux encodings and control bundle.
package cpu_pkg;
  typedef enum logic [3:0] {
    F_MAR  = 4'd0,
    F_RD   = 4'd1,
    F_MBR  = 4'd2,
    F_IR   = 4'd3,
    DECODE = 4'd4,
    X_RD   = 4'd5,
    X_MBR  = 4'd6,
    X_ACC  = 4'd7,
    X_WR   = 4'd8,
    HALT   = 4'd9
  } state_t;
  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_SUBT     = 4'h4;
  localparam logic [3:0] OP_HALT     = 4'h7;
  localparam logic [3:0] OP_SKIPCOND = 4'h8;
  localparam logic [3:0] OP_JUMP     = 4'h9;
  localparam logic [3:0] OP_CLEAR    = 4'hA;
  localparam logic [1:0] ACC_MBR  = 2'd0;
  localparam logic [1:0] ACC_ALU  = 2'd1;
  localparam logic [1:0] ACC_ZERO = 2'd2;
  localparam logic MBR_MEM = 1'b0;
  localparam logic MBR_ACC = 1'b1;
  localparam logic PC_INC  = 1'b0;
  localparam logic PC_IR   = 1'b1;
  localparam logic MAR_PC  = 1'b0;
  localparam logic MAR_IR  = 1'b1;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  typedef struct packed {
    logic       pc_we;
    logic       pc_sel;
    logic       mar_we;
    logic       mar_sel;
    logic       mbr_we;
    logic       mbr_sel;
    logic       ir_we;
    logic       acc_we;
    logic [1:0] acc_sel;
    logic [3:0] alu_op;
    logic       mem_we;
    logic       instr_done;
    logic       illegal_op;
    logic       halted;
  } ctrl_t;
endpackage

// File: rtl/control_sequencer_skip_eval.sv
// skip_eval: SKIPCOND test on the two's-complement accumulator.
module skip_eval (
  input  logic [1:0]  cond,
  input  logic [15:0] acc,
  output logic        skip
);
  logic w_zero;
  assign w_zero = (acc == 16'd0);
  assign skip = (cond == 2'd0) ? acc[15] :
                (cond == 2'd1) ? w_zero :
                (cond == 2'd2) ? (!acc[15] && !w_zero) : 1'b0;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute control for the accumulator CPU.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPC_W = 4,
  parameter int ADDR_W = 12,
  parameter int HALT_ON_ILLEGAL = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic [OPC_W+ADDR_W-1:0] ir_in,
  input  logic [15:0]             acc_in,
  output logic                    pc_we,
  output logic                    pc_sel,
  output logic                    mar_we,
  output logic                    mar_sel,
  output logic                    mbr_we,
  output logic                    mbr_sel,
  output logic                    ir_we,
  output logic                    acc_we,
  output logic [1:0]              acc_sel,
  output logic [3:0]              alu_op,
  output logic                    mem_we,
  output logic                    instr_done,
  output logic                    illegal_op,
  output logic                    halted,
  output logic [3:0]              state_dbg
);
  state_t r_state, w_next;
  ctrl_t w_c, w_out;
  logic [OPC_W-1:0] w_opc;
  logic w_skip;
  logic w_unused;
  assign w_opc = ir_in[OPC_W+ADDR_W-1 -: OPC_W];
  assign w_unused = ^ir_in[ADDR_W-3:0];
  skip_eval u_skip (
    .cond (ir_in[ADDR_W-1 -: 2]),
    .acc  (acc_in),
    .skip (w_skip)
  );
  always_ff @(posedge clock) r_state <= reset ? F_MAR : w_next;
  always_comb begin
    w_next = r_state;
    w_c = '0;
    case (r_state)
      F_MAR: if (run) begin
        w_c.mar_we = 1'b1;
        w_c.mar_sel = MAR_PC;
        w_next = F_RD;
      end
      F_RD: w_next = F_MBR;
      F_MBR: begin
        w_c.mbr_we = 1'b1;
        w_c.mbr_sel = MBR_MEM;
        w_c.pc_we = 1'b1;
        w_c.pc_sel = PC_INC;
        w_next = F_IR;
      end
      F_IR: begin
        w_c.ir_we = 1'b1;
        w_next = DECODE;
      end
      DECODE: case (w_opc)
        OP_LOAD, OP_ADD, OP_SUBT: begin
          w_c.mar_we = 1'b1;
          w_c.mar_sel = MAR_IR;
          w_next = X_RD;
        end
        OP_STORE: begin
          w_c.mar_we = 1'b1;
          w_c.mar_sel = MAR_IR;
          w_c.mbr_we = 1'b1;
          w_c.mbr_sel = MBR_ACC;
          w_next = X_WR;
        end
        OP_HALT: begin
          w_c.instr_done = 1'b1;
          w_next = HALT;
        end
        OP_SKIPCOND: begin
          w_c.pc_we = w_skip;
          w_c.pc_sel = PC_INC;
          w_c.instr_done = 1'b1;
          w_next = F_MAR;
        end
        OP_JUMP: begin
          w_c.pc_we = 1'b1;
          w_c.pc_sel = PC_IR;
          w_c.instr_done = 1'b1;
          w_next = F_MAR;
        end
        OP_CLEAR: begin
          w_c.acc_we = 1'b1;
          w_c.acc_sel = ACC_ZERO;
          w_c.instr_done = 1'b1;
          w_next = F_MAR;
        end
        default: begin
          w_c.illegal_op = 1'b1;
          w_c.instr_done = (HALT_ON_ILLEGAL == 0);
          w_next = (HALT_ON_ILLEGAL != 0) ? HALT : F_MAR;
        end
      endcase
      X_RD: w_next = X_MBR;
      X_MBR: begin
        w_c.mbr_we = 1'b1;
        w_c.mbr_sel = MBR_MEM;
        w_next = X_ACC;
      end
      X_ACC: begin
        w_c.acc_we = 1'b1;
        w_c.acc_sel = (w_opc == OP_LOAD) ? ACC_MBR : ACC_ALU;
        w_c.alu_op = (w_opc == OP_SUBT) ? ALU_SUB : ALU_ADD;
        w_c.instr_done = 1'b1;
        w_next = F_MAR;
      end
      X_WR: begin
        w_c.mem_we = 1'b1;
        w_c.instr_done = 1'b1;
        w_next = F_MAR;
      end
      HALT: w_c.halted = 1'b1;
      default: w_next = F_MAR;
    endcase
  end
  // Reset masks every control output so an aborted instruction writes nothing.
  assign w_out = reset ? '0 : w_c;
  assign {pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel, ir_we, acc_we,
          acc_sel, alu_op, mem_we, instr_done, illegal_op, halted} = w_out;
  assign state_dbg = r_state;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed per-cycle vectors checked through a scoreboard queue.
module tb_control_sequencer;
  localparam logic [17:0] PCWE = 18'h20000, PCSEL = 18'h10000, MARWE = 18'h08000,
    MARSEL = 18'h04000, MBRWE = 18'h02000, MBRSEL = 18'h01000, IRWE = 18'h00800,
    ACCWE = 18'h00400, AC_ALU = 18'h00100, AC_ZERO = 18'h00200, A_SUB = 18'h00010,
    MEMWE = 18'h00008, DONE = 18'h00004, ILL = 18'h00002, HLT = 18'h00001;
  typedef struct {
    string       nm;
    logic [25:0] v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic [15:0] ir_in = '0, acc_in = '0;
  logic pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel, ir_we, acc_we, mem_we;
  logic instr_done, illegal_op, halted;
  logic [1:0] acc_sel;
  logic [3:0] alu_op, state_dbg;
  logic h_pc_we, h_pc_sel, h_mar_we, h_mar_sel, h_mbr_we, h_mbr_sel, h_ir_we, h_acc_we;
  logic h_mem_we, h_done, h_ill, h_halted;
  logic [1:0] h_acc_sel;
  logic [3:0] h_alu_op, h_state;
  exp_t q[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  control_sequencer #(.HALT_ON_ILLEGAL(0)) u0 (
    .clock(clk), .reset(rst), .run(run), .ir_in(ir_in), .acc_in(acc_in),
    .pc_we(pc_we), .pc_sel(pc_sel), .mar_we(mar_we), .mar_sel(mar_sel),
    .mbr_we(mbr_we), .mbr_sel(mbr_sel), .ir_we(ir_we), .acc_we(acc_we),
    .acc_sel(acc_sel), .alu_op(alu_op), .mem_we(mem_we), .instr_done(instr_done),
    .illegal_op(illegal_op), .halted(halted), .state_dbg(state_dbg)
  );
  control_sequencer #(.HALT_ON_ILLEGAL(1)) u1 (
    .clock(clk), .reset(rst), .run(run), .ir_in(ir_in), .acc_in(acc_in),
    .pc_we(h_pc_we), .pc_sel(h_pc_sel), .mar_we(h_mar_we), .mar_sel(h_mar_sel),
    .mbr_we(h_mbr_we), .mbr_sel(h_mbr_sel), .ir_we(h_ir_we), .acc_we(h_acc_we),
    .acc_sel(h_acc_sel), .alu_op(h_alu_op), .mem_we(h_mem_we), .instr_done(h_done),
    .illegal_op(h_ill), .halted(h_halted), .state_dbg(h_state)
  );
  logic [25:0] act;
  assign act = {h_state, state_dbg, pc_we, pc_sel, mar_we, mar_sel, mbr_we, mbr_sel,
                ir_we, acc_we, acc_sel, alu_op, mem_we, instr_done, illegal_op, halted};
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (act !== e.v) begin
        fails++;
        $display("FAIL %s: got %h expected %h", e.nm, act, e.v);
      end
    end
  end
  task automatic cyc(input logic r, input logic rn, input logic [15:0] ir,
                     input logic [15:0] ac, input logic [3:0] st, input logic [3:0] st1,
                     input logic [17:0] f, input string nm);
    exp_t e;
    rst = r;
    run = rn;
    ir_in = ir;
    acc_in = ac;
    e.nm = nm;
    e.v = {st1, st, f};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic cy(input logic rn, input logic [15:0] ir, input logic [15:0] ac,
                    input logic [3:0] st, input logic [17:0] f, input string nm);
    cyc(1'b0, rn, ir, ac, st, st, f, nm);
  endtask
  task automatic fetch(input logic [15:0] ir, input logic [15:0] ac, input logic mid,
                       input string nm);
    cy(1'b1, ir, ac, 4'd0, MARWE, {nm, " f_mar"});
    cy(mid, ir, ac, 4'd1, '0, {nm, " f_rd"});
    cy(mid, ir, ac, 4'd2, MBRWE | PCWE, {nm, " f_mbr"});
    cy(mid, ir, ac, 4'd3, IRWE, {nm, " f_ir"});
  endtask
  task automatic mem_op(input logic [15:0] ir, input logic [17:0] last, input string nm);
    fetch(ir, 16'h0, 1'b1, nm);
    cy(1'b1, ir, 16'h0, 4'd4, MARWE | MARSEL, {nm, " decode"});
    cy(1'b1, ir, 16'h0, 4'd5, '0, {nm, " x_rd"});
    cy(1'b1, ir, 16'h0, 4'd6, MBRWE, {nm, " x_mbr"});
    cy(1'b1, ir, 16'h0, 4'd7, last, {nm, " x_acc"});
  endtask
  task automatic one_shot(input logic [15:0] ir, input logic [15:0] ac,
                          input logic [17:0] dec, input string nm);
    fetch(ir, ac, 1'b1, nm);
    cy(1'b1, ir, ac, 4'd4, dec, {nm, " decode"});
  endtask
  initial begin
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b1, 16'h0, 16'h0, 4'd0, 4'd0, '0, "reset");
    mem_op(16'h1005, ACCWE | DONE, "load");
    mem_op(16'h4010, ACCWE | AC_ALU | A_SUB | DONE, "subt");
    mem_op(16'h3001, ACCWE | AC_ALU | DONE, "add");
    fetch(16'h2020, 16'h1234, 1'b1, "store");
    cy(1'b1, 16'h2020, 16'h1234, 4'd4, MARWE | MARSEL | MBRWE | MBRSEL, "store decode");
    cy(1'b1, 16'h2020, 16'h1234, 4'd8, MEMWE | DONE, "store x_wr");
    one_shot(16'h8400, 16'h0000, PCWE | DONE, "skip eq taken");
    one_shot(16'h8400, 16'h0003, DONE, "skip eq not");
    one_shot(16'h8000, 16'h8000, PCWE | DONE, "skip lt taken");
    one_shot(16'h8000, 16'h0005, DONE, "skip lt not");
    one_shot(16'h8800, 16'h0001, PCWE | DONE, "skip gt taken");
    one_shot(16'h8800, 16'hFFFF, DONE, "skip gt neg");
    one_shot(16'h8800, 16'h0000, DONE, "skip gt zero");
    one_shot(16'h8C00, 16'h0000, DONE, "skip never");
    fetch(16'h9123, 16'h0, 1'b0, "jump run low");
    cy(1'b0, 16'h9123, 16'h0, 4'd4, PCWE | PCSEL | DONE, "jump decode");
    one_shot(16'hA000, 16'h0, ACCWE | AC_ZERO | DONE, "clear");
    fetch(16'hF000, 16'h0, 1'b1, "illegal");
    cy(1'b1, 16'hF000, 16'h0, 4'd4, ILL | DONE, "illegal decode");
    cyc(1'b0, 1'b0, 16'hF000, 16'h0, 4'd0, 4'd9, '0, "illegal continue/halt");
    cyc(1'b0, 1'b0, 16'hF000, 16'h0, 4'd0, 4'd9, '0, "illegal hold");
    cyc(1'b1, 1'b0, 16'h0, 16'h0, 4'd0, 4'd9, '0, "illegal reset");
    one_shot(16'h7000, 16'h0, DONE, "halt");
    for (int i = 0; i < 20; i++)
      cy(i[0], 16'h7000, 16'h0, 4'd9, HLT, "halt held");
    cyc(1'b1, 1'b1, 16'h7000, 16'h0, 4'd9, 4'd9, '0, "halt reset");
    for (int i = 0; i < 10; i++)
      cy(1'b0, 16'h1005, 16'h0, 4'd0, '0, "idle run low");
    fetch(16'h3001, 16'h0, 1'b1, "add abort");
    cy(1'b1, 16'h3001, 16'h0, 4'd4, MARWE | MARSEL, "add abort decode");
    cy(1'b1, 16'h3001, 16'h0, 4'd5, '0, "add abort x_rd");
    cyc(1'b1, 1'b1, 16'h3001, 16'h0, 4'd6, 4'd6, '0, "add abort reset");
    cy(1'b0, 16'h3001, 16'h0, 4'd0, '0, "add abort restart");
    cy(1'b1, 16'h3001, 16'h0, 4'd0, MARWE, "add abort refetch");
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
